button_conditioner: RTL and testbench

- Turns a raw, asynchronous, bouncing push-button input into a clean debounced level and a single-cycle press pulse `a`.
- Sits directly upstream of the 6-bit event counter, driving that counter's `a` input, so the counter advances exactly once per physical press.
- Contains a 2-flop synchronizer, a 4-state debounce FSM with a stability counter, and an optional hold-to-repeat generator.

---
 rtl/button_conditioner.sv | 168 ++++++++++++++++
 tb/tb_button_conditioner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Purpose: synchronizes and debounces a bouncing push-button into a clean level and a one-cycle press pulse `a`.
// Latency: `a`/`btn_level` follow a stable input change by 1+DEBOUNCE_CYCLES edges; no backpressure (free-running, no handshake).
// Build option: define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses on `a` (REPEAT_DELAY/REPEAT_PERIOD).
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic a,
    output logic btn_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          a_q, a_d;
    logic          btn_level_q, btn_level_d;
    logic          press_evt;
    logic          rep_evt;

    // Debounce FSM: a candidate change is accepted only after DEBOUNCE_CYCLES agreeing samples.
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_evt = 1'b0;
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d   = PRESSED;
                        press_evt = 1'b1;
                    end else begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CW'(1);
                    end
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d   = PRESSED;
                    cnt_d     = '0;
                    press_evt = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CW'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        a_d         = press_evt | rep_evt;
        btn_level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= 1'b0;
            btn_level_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            btn_level_q <= btn_level_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);

    logic [RW-1:0] rep_q, rep_d;
    logic [RW-1:0] rep_inc;
    logic          first_q, first_d;

    // Counts only PRESSED-to-PRESSED cycles, so time spent in RELEASE_WAIT is frozen out.
    always_comb begin
        rep_d   = rep_q;
        first_d = first_q;
        rep_evt = 1'b0;
        rep_inc = rep_q + RW'(1);
        if (state_d == IDLE) begin
            rep_d   = '0;
            first_d = 1'b1;
        end else if ((state_q == PRESSED) && (state_d == PRESSED)) begin
            if (rep_inc == (first_q ? R_DELAY : R_PERIOD)) begin
                rep_evt = 1'b1;
                rep_d   = '0;
                first_d = 1'b0;
            end else begin
                rep_d = rep_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rep_q   <= '0;
            first_q <= 1'b1;
        end else begin
            rep_q   <= rep_d;
            first_q <= first_d;
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
    assign rep_evt           = 1'b0;
`endif

    assign a         = a_q;
    assign btn_level = btn_level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed press/bounce/glitch/reset steps then random button activity.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_raw = 1'b0;
    logic a;
    logic btn_level;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .a        (a),
        .btn_level(btn_level)
    );

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int p0;

    // Reference model state: synchronizer stages, debounced level, samples seen since last change.
    bit m_s1, m_s2, m_lvl, m_a, m_pressed;
    int age;
    bit seen_q[$];

    function automatic bit repeat_due(input int c);
        return (c == RD) || (c > RD && ((c - RD) % RP) == 0);
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Level flips once the last D synchronized samples since the previous change all disagree with it.
    task automatic model_edge(input logic r, input logic b);
        bit seen;
        bit flip;
        m_a = 1'b0;
        if (r !== 1'b1) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_pressed = 0; age = 0;
            seen_q.delete();
            return;
        end
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = b;
        seen_q.push_back(seen);
        if (seen_q.size() > 64) void'(seen_q.pop_front());
        flip = (seen_q.size() >= D);
        if (flip) begin
            for (int i = 0; i < D; i++)
                if (seen_q[seen_q.size() - 1 - i] == m_lvl) flip = 0;
        end
        if (flip) begin
            m_lvl = !m_lvl;
            seen_q.delete();
            age = 0;
            m_pressed = m_lvl;
            m_a = m_lvl;
        end else if (m_lvl) begin
`ifdef BTN_AUTOREPEAT_EN
            if (m_pressed && seen) begin
                age++;
                if (repeat_due(age)) m_a = 1'b1;
            end
`endif
            m_pressed = seen;
        end
    endtask

    task automatic step(input logic r, input logic b);
        @(negedge clk);
        rst = r;
        btn_raw = b;
        @(posedge clk);
        model_edge(r, b);
        #1;
        check("a_vs_model", a, m_a);
        check("level_vs_model", btn_level, m_lvl);
        if (a === 1'b1) pulses++;
    endtask

    initial begin
        // Reset with the button toggling
        step(1'b0, 1'b1);
        check("rst_a", a, 1'b0);
        check("rst_level", btn_level, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        check("post_rst_level", btn_level, 1'b0);
        check_int("post_rst_pulses", pulses, 0);

        // Clean press: first high sample at edge k, pulse after edge k+5
        p0 = pulses;
        step(1'b1, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1);
            check("press_early_a", a, 1'b0);
        end
        step(1'b1, 1'b1);
        check("press_pulse", a, 1'b1);
        check("press_level", btn_level, 1'b1);
        step(1'b1, 1'b1);
        check("press_fall", a, 1'b0);
        check_int("press_count", pulses - p0, 1);

        // Hold: repeat pulses only with the auto-repeat build
        for (int c = 2; c <= 30; c++) begin
            step(1'b1, 1'b1);
`ifdef BTN_AUTOREPEAT_EN
            check("hold_a", a, repeat_due(c));
`else
            check("hold_a", a, 1'b0);
`endif
        end
`ifdef BTN_AUTOREPEAT_EN
        check_int("hold_count", pulses - p0, 7);
`else
        check_int("hold_count", pulses - p0, 1);
`endif

        // Release: no pulse, level falls after the debounce window
        p0 = pulses;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        check("release_level", btn_level, 1'b0);
        check_int("release_pulses", pulses - p0, 0);

        // Short glitch of 3 cycles
        p0 = pulses;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            check("glitch_level", btn_level, 1'b0);
        end
        check_int("glitch_pulses", pulses - p0, 0);

        // Bounce: toggle for 10 cycles ending high, then hold
        p0 = pulses;
        for (int i = 0; i < 10; i++) step(1'b1, logic'(i % 2));
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1);
            check("bounce_early_a", a, 1'b0);
        end
        step(1'b1, 1'b1);
        check("bounce_pulse", a, 1'b1);
        check_int("bounce_count", pulses - p0, 1);

        // Release bounce while pressed: level holds, no extra pulse
        p0 = pulses;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            check("rel_bounce_level", btn_level, 1'b1);
        end
        check_int("rel_bounce_pulses", pulses - p0, 0);

        // Reset mid-press with the button held
        step(1'b0, 1'b1);
        check("midrst_a", a, 1'b0);
        check("midrst_level", btn_level, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1);
            check("midrst_early_a", a, 1'b0);
        end
        step(1'b1, 1'b1);
        check("midrst_pulse", a, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);

        // Random button activity with occasional resets
        for (int n = 0; n < 300; n++) begin
            int   len;
            logic b;
            len = $urandom_range(1, 12);
            b = logic'($urandom_range(0, 1));
            if ($urandom_range(0, 40) == 0) begin
                step(1'b0, b);
            end else begin
                for (int i = 0; i < len; i++) step(1'b1, b);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
